// File: rtl/cache_pkg.sv
// Shared encodings for the two-way set-associative cache: request types,
// backing-store request types and the controller FSM states.
package cache_pkg;

  typedef enum logic [1:0] {
    ReqRead  = 2'b00,
    ReqWrite = 2'b01,
    ReqFlush = 2'b10,
    ReqRsvd  = 2'b11
  } req_type_e;

  typedef enum logic {
    BsRead  = 1'b0,
    BsWrite = 1'b1
  } bs_type_e;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StBsReq,
    StBsWait,
    StDone
  } state_e;

endpackage

// File: rtl/cache_assoc_if.sv
// Request-side and backing-store-side signals of cache_assoc. The cache is the
// slave; whoever drives requests and serves the backing store is the master.
interface cache_assoc_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic [1:0]        req_type;
  logic              req_do;
  logic [DATA_W-1:0] O_data;
  logic              req_done;
  logic [ADDR_W-1:0] bs_req_addr;
  logic [DATA_W-1:0] bs_req_data;
  logic              bs_req_type;
  logic              bs_req_do;
  logic [DATA_W-1:0] bs_O_data;
  logic              bs_req_done;

  modport master (
    output req_addr, req_data, req_type, req_do, bs_O_data, bs_req_done,
    input  O_data, req_done, bs_req_addr, bs_req_data, bs_req_type, bs_req_do
  );

  modport slave (
    input  req_addr, req_data, req_type, req_do, bs_O_data, bs_req_done,
    output O_data, req_done, bs_req_addr, bs_req_data, bs_req_type, bs_req_do
  );
endinterface

// File: rtl/cache_way.sv
// One way of the cache: per-set valid bit, tag and data word, with an
// asynchronous index read port and a write / invalidate port.
module cache_way #(
  parameter int unsigned SetBits = 6,
  parameter int unsigned TagW    = 24,
  parameter int unsigned DataW   = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [SetBits-1:0] rd_idx_i,
  output logic               rd_valid_o,
  output logic [TagW-1:0]    rd_tag_o,
  output logic [DataW-1:0]   rd_data_o,
  input  logic               wr_en_i,
  input  logic               inv_en_i,
  input  logic [SetBits-1:0] wr_idx_i,
  input  logic [TagW-1:0]    wr_tag_i,
  input  logic [DataW-1:0]   wr_data_i
);
  localparam int unsigned Sets = 2 ** SetBits;

  logic [Sets-1:0]  valid_q, valid_d;
  logic [TagW-1:0]  tag_q  [Sets];
  logic [DataW-1:0] data_q [Sets];

  always_comb begin
    valid_d = valid_q;
    if (wr_en_i) begin
      valid_d[wr_idx_i] = 1'b1;
    end else if (inv_en_i) begin
      valid_d[wr_idx_i] = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data need no reset: they are meaningless while valid is clear.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/cache_assoc.sv
// Two-way set-associative, write-through / write-allocate cache controller.
// Define CACHE_ASSOC_STATS_EN to add hit_count / miss_count outputs.
module cache_assoc
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned SET_BITS = 6
) (
  input  logic         clk,
  input  logic         reset,
  cache_assoc_if.slave bus
`ifdef CACHE_ASSOC_STATS_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
`endif
);
  localparam int unsigned TagW = ADDR_W - SET_BITS - 2;
  localparam int unsigned Sets = 2 ** SET_BITS;

  state_e            state_q, state_d;
  req_type_e         type_q, type_d;
  bs_type_e          bs_type_q, bs_type_d;
  logic [ADDR_W-1:0] addr_q, addr_d, bs_addr_q, bs_addr_d;
  logic [DATA_W-1:0] data_q, data_d, bs_data_q, bs_data_d, rdata_q, rdata_d;
  logic              way_q, way_d;
  logic [Sets-1:0]   lru_q, lru_d;

  logic [SET_BITS-1:0]       idx;
  logic [TagW-1:0]           tag;
  logic [1:0]                way_valid, hit_w, wr_en, inv_en;
  logic [1:0][TagW-1:0]      way_tag;
  logic [1:0][DATA_W-1:0]    way_data;
  logic [DATA_W-1:0]         wr_data, hit_data;
  logic                      hit, hit_way, victim;

  assign idx = addr_q[SET_BITS+1:2];
  assign tag = addr_q[ADDR_W-1:SET_BITS+2];

  for (genvar w = 0; w < 2; w++) begin : g_way
    cache_way #(
      .SetBits(SET_BITS),
      .TagW   (TagW),
      .DataW  (DATA_W)
    ) u_way (
      .clk_i     (clk),
      .rst_i     (reset),
      .rd_idx_i  (idx),
      .rd_valid_o(way_valid[w]),
      .rd_tag_o  (way_tag[w]),
      .rd_data_o (way_data[w]),
      .wr_en_i   (wr_en[w]),
      .inv_en_i  (inv_en[w]),
      .wr_idx_i  (idx),
      .wr_tag_i  (tag),
      .wr_data_i (wr_data)
    );
    assign hit_w[w] = way_valid[w] && (way_tag[w] == tag);
  end

  assign hit      = |hit_w;
  assign hit_way  = hit_w[1];
  assign hit_data = way_data[hit_way];
  // First invalid way wins (way 0 preferred), otherwise the LRU pointer.
  assign victim   = !way_valid[0] ? 1'b0 : (!way_valid[1] ? 1'b1 : lru_q[idx]);

  always_comb begin
    state_d   = state_q;
    type_d    = type_q;
    addr_d    = addr_q;
    data_d    = data_q;
    bs_type_d = bs_type_q;
    bs_addr_d = bs_addr_q;
    bs_data_d = bs_data_q;
    rdata_d   = rdata_q;
    way_d     = way_q;
    lru_d     = lru_q;
    wr_en     = 2'b00;
    inv_en    = 2'b00;
    wr_data   = data_q;

    case (state_q)
      StIdle: begin
        if (bus.req_do) begin
          addr_d  = bus.req_addr;
          data_d  = bus.req_data;
          type_d  = req_type_e'(bus.req_type);
          state_d = StLookup;
        end
      end
      StLookup: begin
        bs_addr_d = addr_q & ~ADDR_W'(3);
        bs_data_d = data_q;
        unique case (type_q)
          ReqRead: begin
            if (hit) begin
              rdata_d     = hit_data;
              lru_d[idx]  = ~hit_way;
              state_d     = StDone;
            end else begin
              way_d     = victim;
              bs_type_d = BsRead;
              state_d   = StBsReq;
            end
          end
          ReqWrite: begin
            way_d     = hit ? hit_way : victim;
            bs_type_d = BsWrite;
            state_d   = StBsReq;
          end
          ReqFlush: begin
            if (hit) begin
              way_d     = hit_way;
              bs_type_d = BsWrite;
              bs_data_d = hit_data;
              state_d   = StBsReq;
            end else begin
              state_d = StDone;
            end
          end
          ReqRsvd: state_d = StDone;
        endcase
      end
      StBsReq: state_d = StBsWait;
      StBsWait: begin
        if (bus.bs_req_done) begin
          state_d = StDone;
          unique case (type_q)
            ReqRead: begin
              wr_en[way_q] = 1'b1;
              wr_data      = bus.bs_O_data;
              rdata_d      = bus.bs_O_data;
              lru_d[idx]   = ~way_q;
            end
            ReqWrite: begin
              wr_en[way_q] = 1'b1;
              lru_d[idx]   = ~way_q;
            end
            ReqFlush: begin
              inv_en[way_q] = 1'b1;
              lru_d[idx]    = way_q;
            end
            ReqRsvd: ;
          endcase
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      type_q    <= ReqRead;
      bs_type_q <= BsRead;
      addr_q    <= '0;
      data_q    <= '0;
      bs_addr_q <= '0;
      bs_data_q <= '0;
      rdata_q   <= '0;
      way_q     <= 1'b0;
      lru_q     <= '0;
    end else begin
      state_q   <= state_d;
      type_q    <= type_d;
      bs_type_q <= bs_type_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      bs_addr_q <= bs_addr_d;
      bs_data_q <= bs_data_d;
      rdata_q   <= rdata_d;
      way_q     <= way_d;
      lru_q     <= lru_d;
    end
  end

  assign bus.req_done    = (state_q == StDone);
  assign bus.O_data      = (state_q == StDone && type_q == ReqRead) ? rdata_q : '0;
  assign bus.bs_req_do   = (state_q == StBsReq);
  assign bus.bs_req_addr = bs_addr_q;
  assign bus.bs_req_data = bs_data_q;
  assign bus.bs_req_type = bs_type_q;

`ifdef CACHE_ASSOC_STATS_EN
  logic        stat_hit_q, stat_hit_d;
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  // The lookup outcome is remembered so only completed requests are counted.
  always_comb begin
    stat_hit_d = (state_q == StLookup) ? hit : stat_hit_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == StDone && (type_q == ReqRead || type_q == ReqWrite)) begin
      if (stat_hit_q) begin
        hit_cnt_d = hit_cnt_q + 32'd1;
      end else begin
        miss_cnt_d = miss_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_hit_q <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      stat_hit_q <= stat_hit_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule
